// File: rtl/uart_pkg.sv
// Shared types and constants for the FIFO-fed UART transmitter.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      LOAD,
      START,
      DATA,
      PARITY,
      STOP
   } tx_state_t;

   localparam int DATA_BITS            = 8;
   localparam int DEFAULT_CLKS_PER_BIT = 868;

endpackage

// File: rtl/uart_baud_tick.sv
// Baud-period counter: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
module uart_baud_tick
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
   input  logic clock,
   input  logic reset,
   input  logic restart,
   output logic bit_tick
);

   localparam logic [15:0] LAST_CNT = 16'(CLKS_PER_BIT - 1);

   logic [15:0] baud_cnt;

   assign bit_tick = (baud_cnt == LAST_CNT);

   // restart aligns the first bit period of a frame to the cycle after LOAD
   always_ff @(posedge clock) begin
      if (reset || restart || bit_tick) begin
         baud_cnt <= '0;
      end else begin
         baud_cnt <= baud_cnt + 16'd1;
      end
   end

endmodule

// File: rtl/fifo_uart_tx.sv
// Pops bytes from fifo_ram and sends them as UART frames on tx.
// Define UART_TX_PARITY_EN to insert an even-parity bit after the data bits.
module fifo_uart_tx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
   parameter int STOP_BITS    = 1
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       enable,
   input  logic       fifo_empty,
   input  logic [7:0] fifo_data,
   output logic       fifo_read,
   output logic       fifo_enable,
   output logic       tx,
   output logic       busy,
   output logic       frame_done
);

   localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);
   localparam logic       LAST_STOP = (STOP_BITS == 2);

   tx_state_t            state;
   logic [DATA_BITS-1:0] shift_reg;
   logic [2:0]           bit_idx;
   logic                 stop_idx;
   logic                 bit_tick;
`ifdef UART_TX_PARITY_EN
   logic                 parity_bit;
`endif

   assign fifo_enable = enable;

   uart_baud_tick #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) baud (
      .clock   (clock),
      .reset   (reset),
      .restart (state == LOAD),
      .bit_tick(bit_tick)
   );

   // Byte holding register; no reset needed since it is always loaded before use
   always_ff @(posedge clock) begin
      if (state == LOAD) begin
         shift_reg  <= fifo_data;
`ifdef UART_TX_PARITY_EN
         parity_bit <= ^fifo_data;
`endif
      end else if (state == DATA && bit_tick) begin
         shift_reg <= shift_reg >> 1;
      end
   end

   // Outputs are registered, so each is set on the transition into the state that owns it
   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= IDLE;
         tx         <= 1'b1;
         busy       <= 1'b0;
         fifo_read  <= 1'b0;
         frame_done <= 1'b0;
         bit_idx    <= '0;
         stop_idx   <= 1'b0;
      end else begin
         fifo_read  <= 1'b0;
         frame_done <= 1'b0;
         case (state)
            IDLE: begin
               tx <= 1'b1;
               if (enable && !fifo_empty) begin
                  state     <= FETCH;
                  fifo_read <= 1'b1;
                  busy      <= 1'b1;
               end
            end
            FETCH: begin
               state <= LOAD;
            end
            LOAD: begin
               bit_idx <= '0;
               tx      <= 1'b0;
               state   <= START;
            end
            START: begin
               if (bit_tick) begin
                  tx    <= shift_reg[0];
                  state <= DATA;
               end
            end
            DATA: begin
               if (bit_tick) begin
                  bit_idx <= bit_idx + 3'd1;
                  if (bit_idx == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                     tx    <= parity_bit;
                     state <= PARITY;
`else
                     tx       <= 1'b1;
                     stop_idx <= 1'b0;
                     state    <= STOP;
`endif
                  end else begin
                     tx <= shift_reg[1];
                  end
               end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
               if (bit_tick) begin
                  tx       <= 1'b1;
                  stop_idx <= 1'b0;
                  state    <= STOP;
               end
            end
`endif
            STOP: begin
               // frame_done rises together with the return to IDLE
               if (bit_tick) begin
                  if (stop_idx == LAST_STOP) begin
                     state      <= IDLE;
                     busy       <= 1'b0;
                     frame_done <= 1'b1;
                  end else begin
                     stop_idx <= 1'b1;
                  end
               end
            end
            default: begin
               state <= IDLE;
               tx    <= 1'b1;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: queue-based FIFO, frame-position reference model, directed and random traffic.
module tb_fifo_uart_tx;

   localparam int N  = 4;
   localparam int SB = 1;
`ifdef UART_TX_PARITY_EN
   localparam int PAR = 1;
`else
   localparam int PAR = 0;
`endif
   localparam int FRAME = (10 + SB - 1 + PAR) * N;
   localparam int LAST  = FRAME + 1;
   localparam int NC    = 8192;

   logic       clock      = 1'b0;
   logic       reset      = 1'b1;
   logic       enable     = 1'b0;
   logic       fifo_empty = 1'b1;
   logic [7:0] fifo_data  = 8'h00;
   logic       wr_en      = 1'b0;
   logic [7:0] wr_byte    = 8'h00;
   logic       fifo_read, fifo_enable, tx, busy, frame_done;

   fifo_uart_tx #(
      .CLKS_PER_BIT(N),
      .STOP_BITS   (SB)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .enable     (enable),
      .fifo_empty (fifo_empty),
      .fifo_data  (fifo_data),
      .fifo_read  (fifo_read),
      .fifo_enable(fifo_enable),
      .tx         (tx),
      .busy       (busy),
      .frame_done (frame_done)
   );

   always #5 clock = ~clock;

   int n_chk  = 0;
   int n_fail = 0;
   int cyc    = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // fifo_ram stand-in: write port from the bench, read data appears the cycle after fifo_read
   logic [7:0] fq[$];
   always @(posedge clock) begin
      if (wr_en) fq.push_back(wr_byte);
      if (fifo_read) begin
         chk("pop_not_empty", 32'(fq.size() > 0), 32'd1);
         if (fq.size() > 0) fifo_data <= fq.pop_front();
      end
      fifo_empty <= (fq.size() == 0);
   end

   // Reference model: position within the current frame, counted from the FETCH cycle
   int         pos  = -1;
   logic [7:0] cur  = 8'h00;
   logic       fd_e = 1'b0;
   logic [7:0] mq[$];

   function automatic logic exp_tx(input int p, input logic [7:0] b);
      int bi;
      if (p < 2) return 1'b1;
      bi = (p - 2) / N;
      if (bi == 0) return 1'b0;
      if (bi <= 8) return b[bi-1];
      if (PAR == 1 && bi == 9) return ^b;
      return 1'b1;
   endfunction

   task automatic advance();
      if (wr_en) mq.push_back(wr_byte);
      fd_e = 1'b0;
      if (reset) begin
         pos = -1;
      end else if (pos >= 0) begin
         if (pos == LAST) begin
            pos  = -1;
            fd_e = 1'b1;
         end else begin
            pos++;
         end
      end else if (enable && !fifo_empty) begin
         pos = 0;
         cur = (mq.size() > 0) ? mq.pop_front() : 8'h00;
      end
   endtask

   int   rd_log[$];
   int   fall_log[$];
   int   fd_log[$];
   logic hist[NC];
   logic prev_tx   = 1'b1;
   logic want_fall = 1'b0;

   // Compare process: outputs of the last edge vs model, then step model with the inputs of the next edge
   initial begin
      #2;
      advance();
      forever begin
         @(negedge clock);
         #2;
         cyc++;
         chk("tx", 32'(tx), 32'(exp_tx(pos, cur)));
         chk("busy", 32'(busy), 32'(pos >= 0));
         chk("fifo_read", 32'(fifo_read), 32'(pos == 0));
         chk("frame_done", 32'(frame_done), 32'(fd_e));
         chk("fifo_enable", 32'(fifo_enable), 32'(enable));
         if (cyc < NC) hist[cyc] = tx;
         if (fifo_read === 1'b1) begin
            rd_log.push_back(cyc);
            want_fall = 1'b1;
         end
         if (want_fall && prev_tx === 1'b1 && tx === 1'b0) begin
            fall_log.push_back(cyc);
            want_fall = 1'b0;
         end
         if (frame_done === 1'b1) fd_log.push_back(cyc);
         prev_tx = tx;
         advance();
      end
   end

   function automatic logic [7:0] decode(input int f);
      logic [7:0] d;
      for (int i = 0; i < 8; i++) begin
         int idx;
         idx  = f + N * (1 + i) + N / 2;
         d[i] = (idx < NC) ? hist[idx] : 1'bx;
      end
      return d;
   endfunction

   task automatic push(input logic [7:0] b);
      @(negedge clock);
      wr_en   = 1'b1;
      wr_byte = b;
      @(negedge clock);
      wr_en = 1'b0;
   endtask

   task automatic wait_falls(input int target, input int limit);
      int k = 0;
      while (fall_log.size() < target && k < limit) begin
         @(negedge clock);
         k++;
      end
      chk("wait_start_bit", 32'(fall_log.size() >= target), 32'd1);
   endtask

   task automatic wait_dones(input int target, input int limit);
      int k = 0;
      while (fd_log.size() < target && k < limit) begin
         @(negedge clock);
         k++;
      end
      chk("wait_frame_done", 32'(fd_log.size() >= target), 32'd1);
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) @(negedge clock);
   endtask

   initial begin
      int         f, nrd, nfd;
      logic [9:0] pat;
      logic [7:0] rb;

      // 1: reset held for two edges while idle
      repeat (2) @(negedge clock);
      reset = 1'b0;
      #3;
      chk("reset_tx", 32'(tx), 32'd1);
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_fifo_read", 32'(fifo_read), 32'd0);

      // 2: single 0x55 frame
      enable = 1'b1;
      push(8'h55);
      wait_falls(1, 50);
      wait_dones(1, 100);
      f = fall_log[0];
      chk("t2_read_to_start", 32'(f - rd_log[0]), 32'd2);
      chk("t2_start_to_done", 32'(fd_log[0] - f), 32'd40);
      chk("t2_byte", 32'(decode(f)), 32'h55);
      pat = 10'b1010101010;
      for (int k = 0; k < 10; k++)
         for (int j = 0; j < N; j++)
            chk("t2_bit_pattern", 32'(hist[f + N * k + j]), 32'(pat[k]));
      repeat (10) @(negedge clock);
      chk("t2_reads", 32'(rd_log.size()), 32'd1);
      chk("t2_dones", 32'(fd_log.size()), 32'd1);

      // 3: three back-to-back frames
      push(8'h01);
      push(8'h80);
      push(8'hFF);
      wait_dones(4, 300);
      repeat (20) @(negedge clock);
      chk("t3_byte0", 32'(decode(fall_log[1])), 32'h01);
      chk("t3_byte1", 32'(decode(fall_log[2])), 32'h80);
      chk("t3_byte2", 32'(decode(fall_log[3])), 32'hFF);
      chk("t3_gap0", 32'(rd_log[2] - fd_log[1]), 32'd1);
      chk("t3_gap1", 32'(rd_log[3] - fd_log[2]), 32'd1);
      chk("t3_reads", 32'(rd_log.size()), 32'd4);
      chk("t3_empty", 32'(fifo_empty), 32'd1);

      // 4: enable dropped during data bit 3 with a second byte queued
      push(8'hA3);
      push(8'h5A);
      wait_falls(5, 60);
      f = fall_log[4];
      wait_until(f + N + 3 * N + 1);
      enable = 1'b0;
      wait_dones(5, 100);
      chk("t4_byte", 32'(decode(f)), 32'hA3);
      nrd = rd_log.size();
      repeat (60) @(negedge clock);
      chk("t4_no_fetch", 32'(rd_log.size()), 32'(nrd));
      chk("t4_idle", 32'(busy), 32'd0);
      enable = 1'b1;
      wait_falls(6, 20);
      wait_dones(6, 100);
      chk("t4_byte2", 32'(decode(fall_log[5])), 32'h5A);

      // 5: reset during data bit 5
      rb = 8'($urandom_range(0, 255));
      push(rb);
      wait_falls(7, 60);
      f = fall_log[6];
      nfd = fd_log.size();
      wait_until(f + N + 5 * N + 1);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      #3;
      chk("t5_tx", 32'(tx), 32'd1);
      chk("t5_busy", 32'(busy), 32'd0);
      nrd = rd_log.size();
      repeat (60) @(negedge clock);
      chk("t5_no_done", 32'(fd_log.size()), 32'(nfd));
      chk("t5_no_fetch", 32'(rd_log.size()), 32'(nrd));
      chk("t5_idle", 32'(busy), 32'd0);

`ifdef UART_TX_PARITY_EN
      // 6: parity bit values and frame length
      push(8'h07);
      wait_falls(8, 60);
      wait_dones(nfd + 1, 100);
      f = fall_log[7];
      chk("t6_len", 32'(fd_log[nfd] - f), 32'd44);
      chk("t6_parity1", 32'(hist[f + 9 * N + N / 2]), 32'd1);
      push(8'h03);
      wait_falls(9, 60);
      wait_dones(nfd + 2, 100);
      chk("t6_parity0", 32'(hist[fall_log[8] + 9 * N + N / 2]), 32'd0);
`endif

      // Random traffic: sparse writes, enable toggles, occasional reset
      for (int i = 0; i < 1500; i++) begin
         @(negedge clock);
         reset = ($urandom_range(0, 299) == 0);
         if ($urandom_range(0, 49) == 0) enable = ~enable;
         wr_en   = ($urandom_range(0, 39) == 0);
         wr_byte = 8'($urandom);
      end
      @(negedge clock);
      reset  = 1'b0;
      wr_en  = 1'b0;
      enable = 1'b1;
      begin
         int k = 0;
         while ((fq.size() != 0 || busy !== 1'b0) && k < 6000) begin
            @(negedge clock);
            k++;
         end
      end
      repeat (5) @(negedge clock);
      chk("drain_empty", 32'(fq.size()), 32'd0);
      chk("drain_idle", 32'(busy), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
